// File: rtl/video_pkg.sv
// video_pkg: shared scanline mode codes and blank/sync bit positions
package video_pkg;
  localparam logic [1:0] SL_OFF = 2'd0;
  localparam logic [1:0] SL_75  = 2'd1;
  localparam logic [1:0] SL_50  = 2'd2;
  localparam logic [1:0] SL_25  = 2'd3;
  localparam int HB = 0;
  localparam int VB = 1;
  localparam int HS = 0;
  localparam int VS = 1;
endpackage

// File: rtl/scanline_dim.sv
// scanline_dim: combinational per-channel scanline scaler
//   c_i    in  CW  channel value
//   mode_i in  2   scanline intensity code
//   dim_i  in  1   this pixel lies on a darkened line
//   c_o    out CW  scaled channel value
module scanline_dim
  import video_pkg::*;
#(
  parameter int CW = 6
) (
  input  logic [CW-1:0] c_i,
  input  logic [1:0]    mode_i,
  input  logic          dim_i,
  output logic [CW-1:0] c_o
);
  // Each shift truncates on its own, so mode 1 is (c>>1)+(c>>2), never above 0.75*max.
  always_comb
    c_o = !dim_i            ? c_i :
          mode_i == SL_75   ? (c_i >> 1) + (c_i >> 2) :
          mode_i == SL_50   ? c_i >> 1 :
          mode_i == SL_25   ? c_i >> 2 :
          c_i;
endmodule

// File: rtl/scanline_filter.sv
// scanline_filter: post-scandoubler stage darkening alternate lines (CRT scanline look)
//   clock   in  1     system clock
//   reset   in  1     asynchronous active-high reset
//   ce      in  1     pixel clock enable
//   enable  in  1     scandoubler active; 0 forces mode off
//   mode    in  2     0 off, 1 75%, 2 50%, 3 25%
//   iblank  in  2     {vblank, hblank}
//   isync   in  2     {vsync, hsync}
//   irgb    in  RGBW  pixel, R in MSBs
//   oblank  out 2     blank delayed 2 ce cycles
//   osync   out 2     sync delayed 2 ce cycles
//   orgb    out RGBW  filtered pixel, 0 while blanked
// Optional: define SCANLINE_ALT_FIELD_EN to alternate the darkened parity every frame.
module scanline_filter
  import video_pkg::*;
#(
  parameter int RGBW = 18
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ce,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [1:0]      iblank,
  input  logic [1:0]      isync,
  input  logic [RGBW-1:0] irgb,
  output logic [1:0]      oblank,
  output logic [1:0]      osync,
  output logic [RGBW-1:0] orgb
);
  localparam int CW = RGBW / 3;
  logic            hs_prev_q, vs_prev_q, hs_rise, vs_rise;
  logic            line_q, line_d, s1_line_q, dim;
  logic [1:0]      mode_q, mode_d, s1_blank_q, s1_sync_q;
  logic [RGBW-1:0] s1_rgb_q, dim_rgb, rgb_d;
  assign hs_rise = isync[HS] & ~hs_prev_q;
  assign vs_rise = isync[VS] & ~vs_prev_q;
`ifdef SCANLINE_ALT_FIELD_EN
  logic field_q, field_d;
  assign field_d = vs_rise ? ~field_q : field_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) field_q <= 1'b0;
    else if (ce) field_q <= field_d;
  // A new frame starts on the freshly toggled field, so darkened parity flips per frame.
  assign line_d = vs_rise ? field_d : hs_rise ? ~line_q : line_q;
`else
  assign line_d = vs_rise ? 1'b0 : hs_rise ? ~line_q : line_q;
`endif
  // Mode only changes at frame start, except that dropping enable turns dimming off at once.
  assign mode_d = !enable ? SL_OFF : vs_rise ? mode : mode_q;
  assign dim    = s1_line_q & (mode_q != SL_OFF);
  for (genvar g = 0; g < 3; g++) begin : g_ch
    scanline_dim #(.CW(CW)) u_dim (
      .c_i   (s1_rgb_q[g*CW +: CW]),
      .mode_i(mode_q),
      .dim_i (dim),
      .c_o   (dim_rgb[g*CW +: CW])
    );
  end
  assign rgb_d = (s1_blank_q[HB] | s1_blank_q[VB]) ? '0 : dim_rgb;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      line_q     <= 1'b0;
      mode_q     <= SL_OFF;
      s1_line_q  <= 1'b0;
      s1_blank_q <= 2'b11;
      s1_sync_q  <= 2'b00;
      s1_rgb_q   <= '0;
      oblank     <= 2'b11;
      osync      <= 2'b00;
      orgb       <= '0;
    end else if (ce) begin
      hs_prev_q  <= isync[HS];
      vs_prev_q  <= isync[VS];
      line_q     <= line_d;
      mode_q     <= mode_d;
      s1_line_q  <= line_d;
      s1_blank_q <= iblank;
      s1_sync_q  <= isync;
      s1_rgb_q   <= irgb;
      oblank     <= s1_blank_q;
      osync      <= s1_sync_q;
      orgb       <= rgb_d;
    end
endmodule

// File: tb/tb_scanline_filter.sv
// tb_scanline_filter: scoreboard bench for scanline_filter
module tb_scanline_filter;
  logic        clock = 1'b0, reset = 1'b1, ce = 1'b0, enable = 1'b1;
  logic [1:0]  mode = 2'd0, iblank = 2'b11, isync = 2'b00;
  logic [17:0] irgb = '0;
  logic [1:0]  oblank, osync;
  logic [17:0] orgb;
  int checks = 0, errors = 0;
  logic [21:0] q[$];
  logic [21:0] last;
  logic        m_hs, m_vs, m_line, m_field, fpar;
  logic [1:0]  m_mode;
  logic [17:0] fa, fb;
  localparam logic [17:0] W = 18'h3FFFF;
  scanline_filter #(.RGBW(18)) dut (
    .clock(clock), .reset(reset), .ce(ce), .enable(enable), .mode(mode),
    .iblank(iblank), .isync(isync), .irgb(irgb),
    .oblank(oblank), .osync(osync), .orgb(orgb)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [17:0] dimf(input logic [17:0] v, input logic [1:0] m, input logic d);
    logic [17:0] r;
    logic [5:0]  c;
    for (int i = 0; i < 3; i++) begin
      c = v[i*6 +: 6];
      r[i*6 +: 6] = !d ? c : m == 2'd1 ? (c >> 1) + (c >> 2) : m == 2'd2 ? c >> 1 : m == 2'd3 ? c >> 2 : c;
    end
    return r;
  endfunction
  function automatic logic [17:0] lit(input logic odd, input logic [17:0] dv, input logic [17:0] bv);
    return (odd ^ fpar) ? dv : bv;
  endfunction
  task automatic model_reset;
    q.delete();
    last = {2'b11, 2'b00, 18'h0};
    q.push_back(last);
    {m_hs, m_vs, m_line, m_field, fpar} = '0;
    m_mode = 2'd0;
  endtask
  task automatic do_reset;
    @(negedge clock);
    ce = 1'b0;
    reset = 1'b1;
    #1 chk("rst_async", 32'({oblank, osync, orgb}), 32'({2'b11, 2'b00, 18'h0}));
    @(posedge clock);
    #1 chk("rst_hold", 32'({oblank, osync, orgb}), 32'({2'b11, 2'b00, 18'h0}));
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask
  task automatic step(input logic c, input logic [1:0] bl, input logic [1:0] sy, input logic [17:0] v);
    logic hr, vr, ln;
    logic [1:0] md;
    @(negedge clock);
    ce = c; iblank = bl; isync = sy; irgb = v;
    if (c) begin
      hr = sy[0] & ~m_hs;
      vr = sy[1] & ~m_vs;
`ifdef SCANLINE_ALT_FIELD_EN
      if (vr) m_field = ~m_field;
      ln = vr ? m_field : hr ? ~m_line : m_line;
`else
      ln = vr ? 1'b0 : hr ? ~m_line : m_line;
`endif
      md = !enable ? 2'd0 : vr ? mode : m_mode;
      q.push_back({bl, sy, |bl ? 18'h0 : dimf(v, md, ln && md != 2'd0)});
      {m_hs, m_vs, m_line, m_mode} = {sy[0], sy[1], ln, md};
    end
    @(posedge clock);
    #1;
    if (c) begin
      chk("sb_depth", 32'(q.size()), 32'd2);
      if (q.size() > 0) begin
        last = q.pop_front();
        chk("sb_out", 32'({oblank, osync, orgb}), 32'(last));
      end
    end else chk("ce_hold", 32'({oblank, osync, orgb}), 32'(last));
  endtask
  task automatic vs_px(input logic [17:0] v);
    step(1'b1, 2'b00, 2'b10, v);
`ifdef SCANLINE_ALT_FIELD_EN
    fpar = ~fpar;
`endif
  endtask
  task automatic run(input logic [1:0] sy, input logic [17:0] v, input int n);
    step(1'b1, 2'b00, sy, v);
    repeat (n - 1) step(1'b1, 2'b00, 2'b00, v);
  endtask
  initial begin
    do_reset();
    enable = 1'b1; mode = 2'd0;
    run(2'b00, W, 4);
    chk("pass_rgb", 32'(orgb), 32'(W));
    chk("pass_blank", 32'(oblank), 32'd0);
    mode = 2'd2;
    vs_px(W);
    run(2'b00, W, 3);
    chk("m2_line0", 32'(orgb), 32'(lit(1'b0, 18'h1F7DF, W)));
    for (int l = 1; l < 4; l++) begin
      run(2'b01, W, 4);
      chk("m2_line", 32'(orgb), 32'(lit(l[0], 18'h1F7DF, W)));
    end
    mode = 2'd1;
    vs_px({3{6'd40}});
    run(2'b00, {3{6'd40}}, 2);
    run(2'b01, {3{6'd40}}, 4);
    chk("m1_40", 32'(orgb), 32'(lit(1'b1, {3{6'd30}}, {3{6'd40}})));
    mode = 2'd3;
    vs_px(W);
    run(2'b00, W, 2);
    run(2'b01, W, 4);
    chk("m3_63", 32'(orgb), 32'(lit(1'b1, {3{6'd15}}, W)));
    mode = 2'd2;
    vs_px(W);
    run(2'b01, W, 4);
    chk("mid_pre", 32'(orgb), 32'(lit(1'b1, 18'h1F7DF, W)));
    mode = 2'd3;
    run(2'b00, W, 3);
    chk("mid_hold", 32'(orgb), 32'(lit(1'b1, 18'h1F7DF, W)));
    run(2'b01, W, 2);
    run(2'b01, W, 4);
    chk("mid_line3", 32'(orgb), 32'(lit(1'b1, 18'h1F7DF, W)));
    vs_px(W);
    run(2'b01, W, 4);
    chk("mid_new", 32'(orgb), 32'(lit(1'b1, 18'h0F3CF, W)));
    vs_px(W);
    repeat (3) step(1'b1, 2'b01, 2'b00, W);
    chk("blank_rgb", 32'(orgb), 32'd0);
    chk("blank_flag", 32'(oblank), 32'd1);
    step(1'b1, 2'b01, 2'b01, W);
    step(1'b1, 2'b01, 2'b00, W);
    chk("blank_sync", 32'(osync), 32'd1);
    repeat (3) step(1'b0, 2'b10, 2'b11, 18'h12345);
    run(2'b00, W, 2);
    run(2'b01, W, 3);
    do_reset();
    enable = 1'b0; mode = 2'd3;
    vs_px(W);
    run(2'b00, W, 3);
    for (int l = 1; l < 4; l++) begin
      run(2'b01, W, 4);
      chk("en0_line", 32'(orgb), 32'(W));
    end
    enable = 1'b1; mode = 2'd2;
    vs_px(W);
    run(2'b00, W, 3);
    fa = orgb;
    run(2'b01, W, 3);
    vs_px(W);
    run(2'b00, W, 3);
    fb = orgb;
`ifdef SCANLINE_ALT_FIELD_EN
    chk("alt_differs", 32'(fa != fb), 32'd1);
`else
    chk("frame_a_l0", 32'(fa), 32'(W));
    chk("frame_b_l0", 32'(fb), 32'(W));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
